// File: rtl/text_pkg.sv
// Shared types and constants for the character-cell text renderer.
// Holds the colour/palette types and the power-up palette contents.
package text_pkg;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 8;

    typedef logic [5:0] rgb_t;

    typedef struct packed {
        rgb_t fg;
        rgb_t bg;
    } pal_entry_t;

    // Power-up palette; entries past the first four behave like white-on-black.
    function automatic pal_entry_t default_pal(input int unsigned idx);
        pal_entry_t e;
        case (idx)
            0:       e = '{fg: 6'h3F, bg: 6'h00};
            1:       e = '{fg: 6'h00, bg: 6'h1D};
            2:       e = '{fg: 6'h00, bg: 6'h31};
            3:       e = '{fg: 6'h00, bg: 6'h00};
            default: e = '{fg: 6'h3F, bg: 6'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bitmap_rom.sv
// 64-glyph 8x8 character generator; one dot per lookup, MSB is the leftmost column.
// Glyph 0 is blank, 1 is a solid block, 2 is a box outline.
module bitmap_rom (
    input  logic [5:0] i_char,
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    output logic       o_dot
);

    logic [7:0] row_bits;

    always_comb begin
        row_bits = 8'h00;
        case (i_char)
            6'd0: row_bits = 8'h00;
            6'd1: row_bits = 8'hFF;
            6'd2: row_bits = (i_row == 3'd0 || i_row == 3'd7) ? 8'hFF : 8'h81;
            default: row_bits = {i_char, i_row[1:0]} ^ {8{i_row[2]}};
        endcase
    end

    assign o_dot = row_bits[3'd7 - i_col];

endmodule

// File: rtl/text_palette.sv
// Writable fg/bg colour palette: one synchronous write port, one combinational read port.
// A write becomes visible on the read port from the clock after the strobe.
module text_palette
    import text_pkg::*;
#(
    parameter int unsigned PAL_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [PAL_W-1:0] i_wr_idx,
    input  rgb_t             i_wr_fg,
    input  rgb_t             i_wr_bg,
    input  logic [PAL_W-1:0] i_rd_idx,
    output pal_entry_t       o_rd
);

    localparam int unsigned N = 2 ** PAL_W;

    pal_entry_t pal_q [N];
    pal_entry_t pal_d [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            pal_d[i] = pal_q[i];
        end
        if (i_we) begin
            pal_d[i_wr_idx] = '{fg: i_wr_fg, bg: i_wr_bg};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                pal_q[i] <= default_pal(i);
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                pal_q[i] <= pal_d[i];
            end
        end
    end

    assign o_rd = pal_q[i_rd_idx];

endmodule

// File: rtl/text_render_pipe.sv
// Three-stage character-cell renderer: cell address -> glyph dot -> palette colour.
// One pixel per clock, fixed 3-clock latency from x/y/de to o_video/o_de.
module text_render_pipe
    import text_pkg::*;
#(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 60,
    parameter int unsigned COORD_W   = 11,
    parameter int unsigned PAL_W     = 2,
    parameter int unsigned BLINK_LOG = 5,
    localparam int unsigned ADDR_W   = $clog2(COLS * ROWS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_de,
    input  logic               i_frame,
    input  logic [5:0]         i_rgb,
    input  logic               i_sel,
    output logic [ADDR_W-1:0]  o_cell_addr,
    input  logic [5:0]         i_cell_char,
    input  logic [PAL_W:0]     i_cell_attr,
    input  logic               i_pal_we,
    input  logic [PAL_W-1:0]   i_pal_idx,
    input  logic [5:0]         i_pal_fg,
    input  logic [5:0]         i_pal_bg,
    input  logic               i_cur_en,
    input  logic [6:0]         i_cur_col,
    input  logic [5:0]         i_cur_row,
    output logic [5:0]         o_video,
    output logic               o_de
);

    localparam int unsigned CW = COORD_W - 3;

    // Stage 1
    logic [2:0]        cx1_q, cx1_d, cy1_q, cy1_d;
    logic [CW-1:0]     col1_q, col1_d, row1_q, row1_d;
    logic              de1_q, de1_d, sel1_q, sel1_d, inr1_q, inr1_d;
    rgb_t              rgb1_q, rgb1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Stage 2
    logic              dot2_q, dot2_d, blink2_q, blink2_d, hit2_q, hit2_d;
    logic [PAL_W-1:0]  idx2_q, idx2_d;
    logic              de2_q, de2_d, sel2_q, sel2_d, inr2_q, inr2_d;
    rgb_t              rgb2_q, rgb2_d;
    // Stage 3
    rgb_t              video_q, video_d;
    logic              de3_q, de3_d;
    logic [BLINK_LOG-1:0] frame_q, frame_d;

    logic [CW-1:0] col_in, row_in;
    logic          dot_w, phase, d;
    pal_entry_t    pal_rd;

    assign col_in = i_x[COORD_W-1:3];
    assign row_in = i_y[COORD_W-1:3];
    assign phase  = frame_q[BLINK_LOG-1];

    bitmap_rom u_bitmap_rom (
        .i_char (i_cell_char),
        .i_row  (cy1_q),
        .i_col  (cx1_q),
        .o_dot  (dot_w)
    );

    text_palette #(
        .PAL_W (PAL_W)
    ) u_text_palette (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_we     (i_pal_we),
        .i_wr_idx (i_pal_idx),
        .i_wr_fg  (i_pal_fg),
        .i_wr_bg  (i_pal_bg),
        .i_rd_idx (idx2_q),
        .o_rd     (pal_rd)
    );

    always_comb begin
        // S1: cell coordinates and RAM address
        cx1_d  = i_x[2:0];
        cy1_d  = i_y[2:0];
        col1_d = col_in;
        row1_d = row_in;
        de1_d  = i_de;
        sel1_d = i_sel;
        rgb1_d = i_rgb;
        inr1_d = (col_in < CW'(COLS)) && (row_in < CW'(ROWS));
        addr_d = inr1_d ? (ADDR_W'(row_in) * ADDR_W'(COLS) + ADDR_W'(col_in)) : '0;

        // S2: RAM data returns this cycle, aligned with the S1 registers
        dot2_d   = dot_w;
        blink2_d = i_cell_attr[PAL_W];
        idx2_d   = i_cell_attr[PAL_W-1:0];
        hit2_d   = i_cur_en && (col1_q == CW'(i_cur_col)) && (row1_q == CW'(i_cur_row))
                   && (cy1_q == 3'd7);
        de2_d    = de1_q;
        sel2_d   = sel1_q;
        rgb2_d   = rgb1_q;
        inr2_d   = inr1_q;

        // S3: blink suppresses the glyph in phase 1, the cursor inverts it in phase 0
        d = dot2_q;
        if (blink2_q && phase) begin
            d = 1'b0;
        end
        if (hit2_q && !phase) begin
            d = ~d;
        end
        if (!de2_q) begin
            video_d = 6'h00;
        end else if (sel2_q) begin
            video_d = rgb2_q;
        end else if (!inr2_q) begin
            video_d = 6'h00;
        end else begin
            video_d = d ? pal_rd.fg : pal_rd.bg;
        end
        de3_d = de2_q;

        frame_d = i_frame ? frame_q + 1'b1 : frame_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cx1_q    <= '0;
            cy1_q    <= '0;
            col1_q   <= '0;
            row1_q   <= '0;
            de1_q    <= 1'b0;
            sel1_q   <= 1'b0;
            inr1_q   <= 1'b0;
            rgb1_q   <= '0;
            addr_q   <= '0;
            dot2_q   <= 1'b0;
            blink2_q <= 1'b0;
            hit2_q   <= 1'b0;
            idx2_q   <= '0;
            de2_q    <= 1'b0;
            sel2_q   <= 1'b0;
            inr2_q   <= 1'b0;
            rgb2_q   <= '0;
            video_q  <= '0;
            de3_q    <= 1'b0;
            frame_q  <= '0;
        end else begin
            cx1_q    <= cx1_d;
            cy1_q    <= cy1_d;
            col1_q   <= col1_d;
            row1_q   <= row1_d;
            de1_q    <= de1_d;
            sel1_q   <= sel1_d;
            inr1_q   <= inr1_d;
            rgb1_q   <= rgb1_d;
            addr_q   <= addr_d;
            dot2_q   <= dot2_d;
            blink2_q <= blink2_d;
            hit2_q   <= hit2_d;
            idx2_q   <= idx2_d;
            de2_q    <= de2_d;
            sel2_q   <= sel2_d;
            inr2_q   <= inr2_d;
            rgb2_q   <= rgb2_d;
            video_q  <= video_d;
            de3_q    <= de3_d;
            frame_q  <= frame_d;
        end
    end

    assign o_cell_addr = addr_q;
    assign o_video     = video_q;
    assign o_de        = de3_q;

endmodule
